// File: rtl/scalar_mult_controller_if.sv
// Bus between the scalar multiplication sequencer and its point doubling / addition units.
// The controller also forwards the latched field prime and curve coefficient.
interface scalar_mult_controller_if #(
  parameter int unsigned N = 10
);
  logic [N-1:0] p;
  logic [N-1:0] a;

  logic         dbl_reset;
  logic [N-1:0] dbl_x;
  logic [N-1:0] dbl_y;
  logic [N-1:0] dbl_x3;
  logic [N-1:0] dbl_y3;
  logic         dbl_result;
  logic         dbl_infinity;

  logic         add_reset;
  logic [N-1:0] add_x1;
  logic [N-1:0] add_y1;
  logic [N-1:0] add_x2;
  logic [N-1:0] add_y2;
  logic [N-1:0] add_x3;
  logic [N-1:0] add_y3;
  logic         add_result;
  logic         add_infinity;

  modport master (
    output p, a,
    output dbl_reset, dbl_x, dbl_y,
    input  dbl_x3, dbl_y3, dbl_result, dbl_infinity,
    output add_reset, add_x1, add_y1, add_x2, add_y2,
    input  add_x3, add_y3, add_result, add_infinity
  );

  modport slave (
    input  p, a,
    input  dbl_reset, dbl_x, dbl_y,
    output dbl_x3, dbl_y3, dbl_result, dbl_infinity,
    input  add_reset, add_x1, add_y1, add_x2, add_y2,
    output add_x3, add_y3, add_result, add_infinity
  );
endinterface

// File: rtl/scalar_mult_controller.sv
// Left-to-right double-and-add sequencer for Q = k*P, driving external doubler and adder units.
// Point at infinity and the Q==P case are resolved here so the units never see them.
module scalar_mult_controller #(
  parameter int unsigned N       = 10,
  parameter int unsigned Timeout = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [N-1:0]             k_i,
  input  logic [N-1:0]             p_i,
  input  logic [N-1:0]             a_i,
  input  logic [N-1:0]             xp_i,
  input  logic [N-1:0]             yp_i,
  scalar_mult_controller_if.master unit_io,
  output logic [N-1:0]             xq_o,
  output logic [N-1:0]             yq_o,
  output logic                     q_infinity_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(Timeout + 1);

  typedef enum logic [3:0] {
    StIdle, StScan, StDblGo, StDblWait, StAddChk, StAddGo, StAddWait, StNext, StDone
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  k_q, k_d, p_q, p_d, a_q, a_d, xp_q, xp_d, yp_q, yp_d;
  logic [IW-1:0] i_q, i_d;
  logic [N-1:0]  xq_q, xq_d, yq_q, yq_d;
  logic          qinf_q, qinf_d;
  logic          sub_q, sub_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  dbl_x_q, dbl_x_d, dbl_y_q, dbl_y_d;
  logic [N-1:0]  add_x1_q, add_x1_d, add_y1_q, add_y1_d;
  logic [N-1:0]  add_x2_q, add_x2_d, add_y2_q, add_y2_d;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    p_d      = p_q;
    a_d      = a_q;
    xp_d     = xp_q;
    yp_d     = yp_q;
    i_d      = i_q;
    xq_d     = xq_q;
    yq_d     = yq_q;
    qinf_d   = qinf_q;
    sub_d    = sub_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    dbl_x_d  = dbl_x_q;
    dbl_y_d  = dbl_y_q;
    add_x1_d = add_x1_q;
    add_y1_d = add_y1_q;
    add_x2_d = add_x2_q;
    add_y2_d = add_y2_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          k_d     = k_i;
          p_d     = p_i;
          a_d     = a_i;
          xp_d    = xp_i;
          yp_d    = yp_i;
          i_d     = IW'(N - 1);
          qinf_d  = 1'b1;
          sub_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (qinf_q) begin
          state_d = StAddChk;
        end else begin
          dbl_x_d = xq_q;
          dbl_y_d = yq_q;
          state_d = StDblGo;
        end
      end
      StDblGo: begin
        cnt_d   = '0;
        state_d = StDblWait;
      end
      StDblWait: begin
        if (unit_io.dbl_result || unit_io.dbl_infinity) begin
          xq_d    = unit_io.dbl_x3;
          yq_d    = unit_io.dbl_y3;
          qinf_d  = unit_io.dbl_infinity;
          state_d = sub_q ? StNext : StAddChk;
        end else if (cnt_q == CW'(Timeout - 1)) begin
          err_d   = 1'b1;
          qinf_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAddChk: begin
        if (!k_q[i_q]) begin
          state_d = StNext;
        end else if (qinf_q) begin
          xq_d    = xp_q;
          yq_d    = yp_q;
          qinf_d  = 1'b0;
          state_d = StNext;
        end else if (xq_q == xp_q && yq_q == yp_q) begin
          // Adding P to itself is a doubling; the adder cannot handle it.
          sub_d   = 1'b1;
          dbl_x_d = xp_q;
          dbl_y_d = yp_q;
          state_d = StDblGo;
        end else begin
          add_x1_d = xq_q;
          add_y1_d = yq_q;
          add_x2_d = xp_q;
          add_y2_d = yp_q;
          state_d  = StAddGo;
        end
      end
      StAddGo: begin
        cnt_d   = '0;
        state_d = StAddWait;
      end
      StAddWait: begin
        if (unit_io.add_result || unit_io.add_infinity) begin
          xq_d    = unit_io.add_x3;
          yq_d    = unit_io.add_y3;
          qinf_d  = unit_io.add_infinity;
          state_d = StNext;
        end else if (cnt_q == CW'(Timeout - 1)) begin
          err_d   = 1'b1;
          qinf_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StNext: begin
        sub_d = 1'b0;
        if (i_q == '0) begin
          state_d = StDone;
        end else begin
          i_d     = i_q - 1'b1;
          state_d = StScan;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      k_q      <= '0;
      p_q      <= '0;
      a_q      <= '0;
      xp_q     <= '0;
      yp_q     <= '0;
      i_q      <= '0;
      xq_q     <= '0;
      yq_q     <= '0;
      qinf_q   <= 1'b1;
      sub_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      dbl_x_q  <= '0;
      dbl_y_q  <= '0;
      add_x1_q <= '0;
      add_y1_q <= '0;
      add_x2_q <= '0;
      add_y2_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      p_q      <= p_d;
      a_q      <= a_d;
      xp_q     <= xp_d;
      yp_q     <= yp_d;
      i_q      <= i_d;
      xq_q     <= xq_d;
      yq_q     <= yq_d;
      qinf_q   <= qinf_d;
      sub_q    <= sub_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      dbl_x_q  <= dbl_x_d;
      dbl_y_q  <= dbl_y_d;
      add_x1_q <= add_x1_d;
      add_y1_q <= add_y1_d;
      add_x2_q <= add_x2_d;
      add_y2_q <= add_y2_d;
    end
  end

  assign unit_io.p         = p_q;
  assign unit_io.a         = a_q;
  assign unit_io.dbl_reset = (state_q == StDblGo);
  assign unit_io.dbl_x     = dbl_x_q;
  assign unit_io.dbl_y     = dbl_y_q;
  assign unit_io.add_reset = (state_q == StAddGo);
  assign unit_io.add_x1    = add_x1_q;
  assign unit_io.add_y1    = add_y1_q;
  assign unit_io.add_x2    = add_x2_q;
  assign unit_io.add_y2    = add_y2_q;

  assign xq_o         = xq_q;
  assign yq_o         = yq_q;
  assign q_infinity_o = qinf_q;
  assign busy_o       = (state_q != StIdle) && (state_q != StDone);
  assign done_o       = (state_q == StDone);
  assign err_o        = err_q;
endmodule

// File: tb/tb_scalar_mult_controller.sv
// Bench for scalar_mult_controller on y^2 = x^3 + 2x + 2 over GF(17) with behavioural unit stubs.
// Expected points come from plain repeated addition; expected unit usage from integer arithmetic.
module tb_scalar_mult_controller;
  localparam int N   = 10;
  localparam int TMO = 16;
  localparam int PR  = 17;
  localparam int AC  = 2;
  localparam int ORD = 19;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] k, p, a, xp, yp;
  logic [N-1:0] xq, yq;
  logic         q_inf, busy, done, err;

  int n_total = 0;
  int n_bad   = 0;
  int dbl_pulses, add_pulses;
  bit dbl_hang = 1'b0;

  scalar_mult_controller_if #(.N(N)) unit_if ();

  scalar_mult_controller #(.N(N), .Timeout(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start),
    .k_i          (k),
    .p_i          (p),
    .a_i          (a),
    .xp_i         (xp),
    .yp_i         (yp),
    .unit_io      (unit_if),
    .xq_o         (xq),
    .yq_o         (yq),
    .q_infinity_o (q_inf),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int md(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  function automatic int inv(input int v, input int m);
    int r = 1;
    for (int j = 0; j < m - 2; j++) r = (r * v) % m;
    return r;
  endfunction

  // General affine point addition with the identity handled explicitly.
  function automatic void ec_add(input int x1, input int y1, input bit i1,
                                 input int x2, input int y2, input bit i2,
                                 input int pm, input int am,
                                 output int x3, output int y3, output bit i3);
    int lam;
    x3 = 0; y3 = 0; i3 = 1'b0;
    if (i1) begin x3 = x2; y3 = y2; i3 = i2; return; end
    if (i2) begin x3 = x1; y3 = y1; i3 = i1; return; end
    if (pm < 2) begin i3 = 1'b1; return; end
    x1 = md(x1, pm); y1 = md(y1, pm); x2 = md(x2, pm); y2 = md(y2, pm);
    if (x1 == x2 && md(y1 + y2, pm) == 0) begin i3 = 1'b1; return; end
    if (x1 == x2) lam = md((3 * x1 * x1 + am) * inv(md(2 * y1, pm), pm), pm);
    else          lam = md((y2 - y1) * inv(md(x2 - x1, pm), pm), pm);
    x3 = md(lam * lam - x1 - x2, pm);
    y3 = md(lam * (x1 - x3) - y1, pm);
  endfunction

  function automatic void ref_mul(input int kk, input int bx, input int by,
                                  output int rx, output int ry, output bit rinf);
    int tx, ty;
    bit ti;
    rx = 0; ry = 0; rinf = 1'b1;
    for (int j = 0; j < kk; j++) begin
      ec_add(rx, ry, rinf, bx, by, 1'b0, PR, AC, tx, ty, ti);
      rx = tx; ry = ty; rinf = ti;
    end
  endfunction

  // Unit usage from the multiple of the base held before each bit (group of prime order).
  function automatic void exp_counts(input int kk, output int nd, output int na);
    int v, m;
    nd = 0; na = 0;
    for (int i = N - 1; i >= 0; i--) begin
      v = (kk >> (i + 1)) % ORD;
      if (v != 0) nd++;
      m = (2 * v) % ORD;
      if (((kk >> i) & 1) == 1) begin
        if (m == 1) nd++;
        else if (m != 0) na++;
      end
    end
  endfunction

  initial begin : dbl_stub
    int cnt, rx, ry;
    bit pend, rinf;
    pend = 1'b0; cnt = 0; rx = 0; ry = 0; rinf = 1'b0;
    unit_if.dbl_result = 1'b0; unit_if.dbl_infinity = 1'b0;
    unit_if.dbl_x3 = '0; unit_if.dbl_y3 = '0;
    forever begin
      @(posedge clk); #1;
      unit_if.dbl_result = 1'b0;
      unit_if.dbl_infinity = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else if (unit_if.dbl_reset) begin
        dbl_pulses++;
        ec_add(int'(unit_if.dbl_x), int'(unit_if.dbl_y), 1'b0,
               int'(unit_if.dbl_x), int'(unit_if.dbl_y), 1'b0,
               int'(unit_if.p), int'(unit_if.a), rx, ry, rinf);
        cnt = $urandom_range(1, 6);
        pend = !dbl_hang;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          unit_if.dbl_x3 = rinf ? N'($urandom) : N'(rx);
          unit_if.dbl_y3 = rinf ? N'($urandom) : N'(ry);
          unit_if.dbl_result = !rinf || ($urandom_range(0, 1) == 1);
          unit_if.dbl_infinity = rinf;
        end
      end
    end
  end

  initial begin : add_stub
    int cnt, rx, ry;
    bit pend, rinf;
    pend = 1'b0; cnt = 0; rx = 0; ry = 0; rinf = 1'b0;
    unit_if.add_result = 1'b0; unit_if.add_infinity = 1'b0;
    unit_if.add_x3 = '0; unit_if.add_y3 = '0;
    forever begin
      @(posedge clk); #1;
      unit_if.add_result = 1'b0;
      unit_if.add_infinity = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else if (unit_if.add_reset) begin
        add_pulses++;
        check_eq("add_operands_distinct",
                 int'(unit_if.add_x1 == unit_if.add_x2 && unit_if.add_y1 == unit_if.add_y2), 0);
        ec_add(int'(unit_if.add_x1), int'(unit_if.add_y1), 1'b0,
               int'(unit_if.add_x2), int'(unit_if.add_y2), 1'b0,
               int'(unit_if.p), int'(unit_if.a), rx, ry, rinf);
        cnt = $urandom_range(1, 6);
        pend = 1'b1;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          unit_if.add_x3 = rinf ? N'($urandom) : N'(rx);
          unit_if.add_y3 = rinf ? N'($urandom) : N'(ry);
          unit_if.add_result = !rinf || ($urandom_range(0, 1) == 1);
          unit_if.add_infinity = rinf;
        end
      end
    end
  end

  task automatic run_case(input int kk, input int bx, input int by, input bit poke);
    int ex, ey, edbl, eadd, cyc;
    bit einf, seen;
    ref_mul(kk, bx, by, ex, ey, einf);
    exp_counts(kk, edbl, eadd);
    @(negedge clk);
    k = N'(kk); xp = N'(bx); yp = N'(by); start = 1'b1;
    dbl_pulses = 0; add_pulses = 0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check_eq("busy_after_start", int'(busy), 1);
      end
      if (poke && cyc == 4) begin
        start = 1'b1; k = N'($urandom); xp = N'($urandom); yp = N'($urandom);
      end
      if (poke && cyc == 5) start = 1'b0;
      if (done) seen = 1'b1;
    end
    check_eq("done_seen", int'(seen), 1);
    check_eq("busy_in_done", int'(busy), 0);
    check_eq("q_infinity", int'(q_inf), int'(einf));
    if (!einf) begin
      check_eq("xq", int'(xq), ex);
      check_eq("yq", int'(yq), ey);
    end
    check_eq("dbl_pulses", dbl_pulses, edbl);
    check_eq("add_pulses", add_pulses, eadd);
    check_eq("err_clear", int'(err), 0);
    if (kk == 0) check_eq("k0_latency", cyc, 3 * N + 1);
    @(negedge clk);
    check_eq("done_one_cycle", int'(done), 0);
    check_eq("idle_not_busy", int'(busy), 0);
    check_eq("q_inf_hold", int'(q_inf), int'(einf));
  endtask

  task automatic wait_dbl_pulse(input string tag);
    int cyc = 0;
    while (!unit_if.dbl_reset && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
    end
    check_eq(tag, int'(unit_if.dbl_reset), 1);
  endtask

  initial begin : stim
    int bx, by, m, cyc;
    bit binf;
    reset = 1'b1; start = 1'b0; k = '0; p = N'(PR); a = N'(AC); xp = '0; yp = '0;
    dbl_pulses = 0; add_pulses = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_xq", int'(xq), 0);
    check_eq("rst_yq", int'(yq), 0);
    check_eq("rst_q_inf", int'(q_inf), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_dbl_reset", int'(unit_if.dbl_reset), 0);
    check_eq("rst_add_reset", int'(unit_if.add_reset), 0);
    check_eq("rst_dbl_x", int'(unit_if.dbl_x), 0);
    check_eq("rst_add_x1", int'(unit_if.add_x1), 0);
    reset = 1'b0;

    run_case(1, 5, 1, 1'b0);
    check_eq("k1_x", int'(xq), 5);
    run_case(2, 5, 1, 1'b0);
    check_eq("k2_x", int'(xq), 6);
    check_eq("k2_y", int'(yq), 3);
    run_case(4, 5, 1, 1'b0);
    run_case(3, 5, 1, 1'b0);
    run_case(0, 5, 1, 1'b0);
    run_case(19, 5, 1, 1'b0);
    run_case(39, 5, 1, 1'b0);
    run_case(21, 5, 1, 1'b0);
    check_eq("k21_x", int'(xq), 6);

    // Reset while the doubler is still working.
    dbl_hang = 1'b1;
    @(negedge clk);
    k = N'(2); xp = N'(5); yp = N'(1); start = 1'b1;
    wait_dbl_pulse("rst_test_dbl_go");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_busy", int'(busy), 0);
    check_eq("rst_mid_q_inf", int'(q_inf), 1);
    check_eq("rst_mid_done", int'(done), 0);
    reset = 1'b0;
    dbl_hang = 1'b0;
    run_case(2, 5, 1, 1'b0);

    // Doubler never answers.
    dbl_hang = 1'b1;
    @(negedge clk);
    k = N'(2); xp = N'(5); yp = N'(1); start = 1'b1;
    wait_dbl_pulse("tmo_dbl_go");
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("tmo_done_delay", cyc, TMO + 1);
    check_eq("tmo_err", int'(err), 1);
    check_eq("tmo_q_inf", int'(q_inf), 1);
    @(negedge clk);
    check_eq("tmo_err_sticky", int'(err), 1);
    check_eq("tmo_done_pulse", int'(done), 0);
    dbl_hang = 1'b0;

    run_case(3, 5, 1, 1'b1);
    for (int t = 0; t < 40; t++) begin
      m = $urandom_range(1, ORD - 1);
      ref_mul(m, 5, 1, bx, by, binf);
      run_case($urandom_range(0, (1 << N) - 1), bx, by, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/scalar_mult_controller.md
Name: scalar_mult_controller

Overview:
- Sequences left-to-right double-and-add scalar multiplication Q = k·P over GF(p).
- Drives one external point_doubling unit and one external point_addition unit, which are instantiated alongside this block at the top level.
- Handles point-at-infinity and the Q==P case itself, so neither unit ever sees those operands.
- Sits between the top-level ECC core interface and the two point-arithmetic units.

Parameters:
- n, 10, field/scalar width in bits (same n as the point units).
- TIMEOUT, 1024, maximum cycles to wait for a unit result before flagging an error.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- k  in  n  scalar.
- p  in  n  field prime.
- a  in  n  curve coefficient.
- xp, yp  in  n  base point P.
- dbl_reset  out  1  one-cycle start pulse to the doubler (doubler reset port).
- dbl_x, dbl_y  out  n  doubler operand.
- dbl_x3, dbl_y3  in  n  doubler result.
- dbl_result, dbl_infinity  in  1  doubler completion flags.
- add_reset  out  1  one-cycle start pulse to the adder.
- add_x1, add_y1, add_x2, add_y2  out  n  adder operands (Q, P).
- add_x3, add_y3  in  n  adder result.
- add_result, add_infinity  in  1  adder completion flags.
- xq, yq  out  n  result Q.
- q_infinity  out  1  result is the point at infinity.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  unit timeout; sticky until the next start or reset.

Behaviour:
- Reset: state IDLE. xq, yq, dbl_*, add_* operand outputs = 0. q_infinity = 1. busy, done, err, dbl_reset, add_reset = 0.
- Reset asserted in any state returns to IDLE next cycle. Any unit operation in progress is abandoned; unit outputs are ignored.
- IDLE: on start, latch k, p, a, xp, yp; set i = n-1, Q = infinity; clear err. Go to SCAN. Input changes after acceptance are ignored.
- SCAN: if q_infinity, go to ADD_CHK (doubling infinity is skipped). Otherwise drive dbl_x/dbl_y = Q and go to DBL_GO.
- DBL_GO: dbl_reset = 1 for exactly this cycle; reset the wait counter; go to DBL_WAIT.
- DBL_WAIT: operands held stable. When dbl_result or dbl_infinity is high:
  - load Q = (dbl_x3, dbl_y3), with q_infinity = dbl_infinity;
  - go to NEXT if the doubling was the Q==P substitute, else ADD_CHK.
- ADD_CHK (all one cycle):
  - k[i]==0: go to NEXT.
  - else if q_infinity: Q = P, q_infinity = 0, go to NEXT.
  - else if xq==xp and yq==yp: set substitute flag, drive the doubler with P, go to DBL_GO.
  - else drive add operands (Q, P) and go to ADD_GO.
- ADD_GO / ADD_WAIT: same rules as DBL_GO / DBL_WAIT using add_reset, add_result and add_infinity. Afterwards go to NEXT.
- NEXT: clear the substitute flag. If i==0, go to DONE; else decrement i and go to SCAN.
- DONE: done = 1 for one cycle, busy = 0, then go to IDLE. xq, yq and q_infinity hold until the next accepted start.
- Timeout: if a WAIT state lasts TIMEOUT cycles, set err = 1, q_infinity = 1, and go to DONE.
- A start pulse while busy is ignored.
- Simultaneous result and infinity from a unit: infinity wins (q_infinity = 1).
- Latency: SCAN, ADD_CHK, NEXT, GO are 1 cycle each; WAIT is unit latency plus 1.
  - k=0: done is high exactly 3n+1 cycles after the start-sampling edge (31 for n=10).
- Whenever q_infinity = 1, xq and yq are don't-care.

Test Plan:
All cases use p=17, a=2, P=(5,1) (group order 19).
- k=1 -> done, Q=(5,1), q_infinity=0; dbl_reset and add_reset never pulse.
- k=2 -> Q=(6,3); k=4 -> Q=(3,1); k=3 -> Q=(10,6). Exactly one dbl_reset pulse per non-infinity scan step.
- k=0 -> q_infinity=1, done exactly 31 cycles after start, no unit pulses. k=19 -> q_infinity=1 via add_infinity.
- k=39 -> Q reaches infinity mid-scan, the doubling is skipped, then Q=P is loaded; final Q=(5,1). k=21 -> the Q==P step is routed to the doubler; final Q=(6,3).
- Reset asserted during DBL_WAIT -> IDLE next cycle, busy=0, q_infinity=1. A following start with k=2 -> Q=(6,3).
- Doubler stub never responds, TIMEOUT=16 -> err=1 and a done pulse after 16 wait cycles. Start pulsed while busy -> ignored; the result is unchanged.
